imem_boot_loader: RTL

- Writer side of the instruction-memory path: receives a byte stream, assembles little-endian 32-bit instruction words and writes them into instruction memory.
- The fetch/decode path later reads those words back.
- Holds the RV32I core in reset until a complete program image has been loaded and its checksum verified.
- Sits between the host byte link (UART/SPI bridge) and the instruction memory write port.

---
 rtl/boot_pkg.sv | 18 +
 rtl/boot_word_assembler.sv | 40 ++++
 rtl/imem_boot_loader.sv | 107 ++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding and frame field widths.
package boot_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 16;
  localparam int BYTE_W     = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_LO = 3'd1;
  localparam state_t ST_LEN_HI = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_CHK    = 3'd4;
  localparam state_t ST_DONE   = 3'd5;
  localparam state_t ST_ERROR  = 3'd6;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs accepted payload bytes little-endian into 32-bit words and XORs them into a checksum.
// word_ready is combinational on the 4th byte; no backpressure, every offered byte is consumed.
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_dat,
  output logic              word_ready,
  output logic [31:0]       word,
  output logic [BYTE_W-1:0] chk_acc
);

  logic [23:0] lanes;
  logic [1:0]  byte_idx;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      lanes    <= '0;
      byte_idx <= '0;
      chk_acc  <= '0;
    end else if (byte_vld) begin
      chk_acc  <= chk_acc ^ byte_dat;
      byte_idx <= byte_idx + 2'd1;
      case (byte_idx)
        2'd0:    lanes[7:0]   <= byte_dat;
        2'd1:    lanes[15:8]  <= byte_dat;
        2'd2:    lanes[23:16] <= byte_dat;
        default: lanes        <= lanes;
      endcase
    end
  end

  // The top lane bypasses the register so the word is complete on the 4th byte's edge.
  assign word       = {byte_dat, lanes};
  assign word_ready = byte_vld && (byte_idx == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checked byte frame into instruction memory and releases core reset on success.
// Memory write lands one cycle after each 4th payload byte; s_ready depends only on state.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  localparam logic [LEN_W-1:0]  MAX_N = LEN_W'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_next;
  logic              accept;
  logic              idle_like;
  logic              asm_clear;
  logic              word_ready;
  logic [31:0]       word;
  logic [BYTE_W-1:0] chk_acc;

  assign s_ready    = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_DATA)   || (state == ST_CHK);
  assign accept     = s_valid && s_ready;
  assign idle_like  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign asm_clear  = idle_like && start;
  assign len_next   = {s_data, len[7:0]};
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERROR);
  assign core_rst_n = (state == ST_DONE);

  boot_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (asm_clear),
    .byte_vld   (accept && (state == ST_DATA)),
    .byte_dat   (s_data),
    .word_ready (word_ready),
    .word       (word),
    .chk_acc    (chk_acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      len        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_LEN_LO: begin
          if (accept) begin
            len[7:0] <= s_data;
            state    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len <= len_next;
            if (len_next > MAX_N)        state <= ST_ERROR;
            else if (len_next == '0)     state <= ST_CHK;
            else                         state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (word_ready) begin
            imem_we    <= 1'b1;
            imem_addr  <= BASE + ADDR_W'(word_count);
            imem_wdata <= word;
            word_count <= word_count + 16'd1;
            if (word_count + 16'd1 == len) state <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (accept) state <= (s_data == chk_acc) ? ST_DONE : ST_ERROR;
        end
        default: begin
          // IDLE, DONE and ERROR all restart the same way.
          if (start) begin
            state      <= ST_LEN_LO;
            word_count <= '0;
          end
        end
      endcase
    end
  end

endmodule
